ad_capture_ctrl: RTL
====================

Name: ad_capture_ctrl

Overview:
Acquisition sequencer in the ADC clock domain. It selects the internal or external trigger, waits a programmable delay, then captures a programmed number of decimated 8-bit ADC samples. Samples are packed in pairs into 16-bit words and written into the AD-to-Ethernet FIFO write port. It reports busy, done, overrun and missed-trigger status to the command/session logic.

Parameters:
CNT_W, 16, width of sample-count and delay fields
MISS_W, 8, width of the saturating missed-trigger counter

Ports:
clk_ad_180M  in  1  ADC sample clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_run  in  1  enable; level from clk_sys domain, 2-FF synchronised inside
i_outmode  in  1  1 = use i_outtrig, 0 = use i_intrig; 2-FF synchronised
i_intrig  in  1  internal trigger level/pulse (≥2 clk wide); 2-FF synchronised
i_outtrig  in  1  external trigger (≥2 clk wide); 2-FF synchronised
i_delay  in  CNT_W  samples of delay from trigger accept to first capture
i_count  in  CNT_W  number of bytes to capture
i_rate  in  3  decimation: take one sample every 2^i_rate clocks
i_ad_data  in  8  raw ADC byte
i_fifo_full  in  1  FIFO write-side full
o_fifo_wr  out  1  FIFO write strobe, one clock per word
o_fifo_data  out  16  packed word: first byte [7:0], second byte [15:8]
o_busy  out  1  high from trigger accept until return to IDLE
o_done  out  1  one-clock pulse on normal completion
o_overrun  out  1  sticky: a word was dropped because FIFO was full
o_trig_miss  out  MISS_W  saturating count of triggers ignored while busy

Behaviour:
- Reset: all outputs 0, state IDLE, synchronisers 0, ad_q 0.
- ad_q: i_ad_data registered once. All captured bytes are taken from ad_q.
- Trigger edge: rising edge of the synchronised selected trigger, detected with one extra register. Edge detect cycle = T.
- IDLE: if run_s and edge at T, latch i_delay, i_count and i_rate; clear o_overrun; move to DELAY at T+1.
- If run_s is low, edges are ignored and o_trig_miss is not incremented.
- Latched count 0: go straight to DONE. No writes are issued.
- DELAY: down-counter loaded with the latched delay D. Transition to CAPTURE when it reaches 0. D=0 means CAPTURE is entered at T+1.
- Sample points: S_k = T+1+D+k·2^rate, for k = 0..count-1.
- CAPTURE, even k: hold the byte in the low half.
- CAPTURE, odd k: form the word and assert o_fifo_wr with o_fifo_data at S_k+1.
- Odd count: the final byte is written at S_last+1 with upper byte 0x00.
- After the final write, enter DONE. DONE lasts one cycle: o_done=1, o_busy drops the next cycle, then IDLE.
- o_busy: 1 in DELAY, CAPTURE and DONE.
- FIFO full at a write cycle: suppress o_fifo_wr, set o_overrun. The sample schedule and byte count continue unchanged.
- Trigger edge while o_busy: ignored; o_trig_miss += 1, saturating at all-ones. o_trig_miss clears only on reset.
- run_s falls mid-operation: return to IDLE on the next clock. No o_done, no write of any pending partial word. o_overrun is kept.
- i_delay, i_count, i_rate and i_outmode changes during operation do not affect the current capture (values are latched). An i_outmode change affects the next edge selection only.
- Counter widths: the byte counter and the decimation counter are CNT_W and 8 bits respectively. No wrap within a capture.

Test Plan:
- intrig, delay=0, count=4, rate=0, ramp ADC 0x10,0x11,… → exactly 2 writes. Words contain consecutive bytes (first byte in [7:0], second in [15:8]); writes 2 clocks apart; o_done one cycle after the 2nd write; o_busy low after.
- outmode=1, delay=5, count=3, rate=2, ADC = cycle counter → bytes at S_k = T+6+4k; 2 writes, second word upper byte 0x00.
- count=0 trigger → o_busy high 1 cycle, o_done pulse, no o_fifo_wr.
- i_fifo_full held high during the first write, count=6 → words 2 and 3 written, word 1 dropped, o_overrun=1 until next accepted trigger clears it.
- 3 extra trigger edges during a count=100 capture → o_trig_miss=3, capture unaffected. 300 extra edges → saturates at 255.
- i_run dropped mid-CAPTURE after 3 bytes → 1 write seen, no o_done, o_busy low within 3 clocks (sync+1). Reset asserted mid-DELAY → all outputs 0 immediately.

Source files
------------

// File: rtl/ad_capture_if.sv
// ad_capture_if: control, ADC, FIFO write-port and status signals of the
// acquisition sequencer. master = sequencer side, slave = environment side.
interface ad_capture_if #(
   parameter int CNT_W  = 16,
   parameter int MISS_W = 8
);
   logic              i_run;
   logic              i_outmode;
   logic              i_intrig;
   logic              i_outtrig;
   logic [CNT_W-1:0]  i_delay;
   logic [CNT_W-1:0]  i_count;
   logic [2:0]        i_rate;
   logic [7:0]        i_ad_data;
   logic              i_fifo_full;
   logic              o_fifo_wr;
   logic [15:0]       o_fifo_data;
   logic              o_busy;
   logic              o_done;
   logic              o_overrun;
   logic [MISS_W-1:0] o_trig_miss;

   modport master (
      input  i_run, i_outmode, i_intrig, i_outtrig, i_delay, i_count, i_rate,
             i_ad_data, i_fifo_full,
      output o_fifo_wr, o_fifo_data, o_busy, o_done, o_overrun, o_trig_miss
   );

   modport slave (
      output i_run, i_outmode, i_intrig, i_outtrig, i_delay, i_count, i_rate,
             i_ad_data, i_fifo_full,
      input  o_fifo_wr, o_fifo_data, o_busy, o_done, o_overrun, o_trig_miss
   );
endinterface

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: triggered acquisition sequencer in the ADC clock domain.
// Waits a latched delay after a trigger edge, then captures decimated ADC
// bytes, packs them in pairs and writes them to the AD-to-Ethernet FIFO.
//
// state   | meaning
// IDLE    | waiting for an accepted trigger edge
// DELAY   | counting down the latched trigger-to-capture delay
// CAPTURE | sampling ad_q every 2^rate clocks, writing each completed pair
// LAST    | final word is on the FIFO port
// DONE    | one-cycle completion pulse, busy still high
module ad_capture_ctrl #(
   parameter int CNT_W  = 16,
   parameter int MISS_W = 8
) (
   input logic          clk_ad_180M,
   input logic          i_rst_n,
   ad_capture_if.master bus
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DELAY   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_LAST    = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   logic [1:0]        run_ff;
   logic [1:0]        mode_ff;
   logic [1:0]        intrig_ff;
   logic [1:0]        outtrig_ff;
   logic              run_s;
   logic              trig_sel;
   logic              trig_q;
   logic              trig_edge;
   logic              accept;
   logic [7:0]        ad_q;
   logic [2:0]        state;
   logic [CNT_W-1:0]  dcnt;
   logic [CNT_W-1:0]  bcnt;
   logic [2:0]        rate_q;
   logic [7:0]        dec_cnt;
   logic [7:0]        dec_reload;
   logic              even_k;
   logic [7:0]        low_byte;
   logic              wr_q;
   logic [15:0]       data_q;
   logic              overrun_q;
   logic [MISS_W-1:0] miss_q;

   assign run_s      = run_ff[1];
   assign trig_sel   = mode_ff[1] ? outtrig_ff[1] : intrig_ff[1];
   assign trig_edge  = trig_sel & ~trig_q;
   assign accept     = trig_edge & run_s & (state == ST_IDLE);
   // interval between samples minus one; rate 7 gives 127, fits 8 bits
   assign dec_reload = 8'((9'd1 << rate_q) - 9'd1);

   // two-flop synchronisers for the slow-domain control and trigger levels
   always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_ff     <= '0;
         mode_ff    <= '0;
         intrig_ff  <= '0;
         outtrig_ff <= '0;
      end else begin
         run_ff     <= {run_ff[0], bus.i_run};
         mode_ff    <= {mode_ff[0], bus.i_outmode};
         intrig_ff  <= {intrig_ff[0], bus.i_intrig};
         outtrig_ff <= {outtrig_ff[0], bus.i_outtrig};
      end
   end

   // ADC byte register and trigger edge-detect history
   always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ad_q   <= '0;
         trig_q <= 1'b0;
      end else begin
         ad_q   <= bus.i_ad_data;
         trig_q <= trig_sel;
      end
   end

   // sequencer: delay countdown, decimated sampling and byte-pair packing
   always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         dcnt     <= '0;
         bcnt     <= '0;
         rate_q   <= '0;
         dec_cnt  <= '0;
         even_k   <= 1'b1;
         low_byte <= '0;
         wr_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         wr_q <= 1'b0;
         if (state != ST_IDLE && !run_s) begin
            // abort drops any half-built word and skips the done pulse
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     rate_q  <= bus.i_rate;
                     bcnt    <= bus.i_count;
                     dcnt    <= bus.i_delay - CNT_W'(1);
                     dec_cnt <= '0;
                     even_k  <= 1'b1;
                     if (bus.i_count == '0)
                        state <= ST_DONE;
                     else if (bus.i_delay == '0)
                        state <= ST_CAPTURE;
                     else
                        state <= ST_DELAY;
                  end
               end
               ST_DELAY: begin
                  if (dcnt == '0)
                     state <= ST_CAPTURE;
                  else
                     dcnt <= dcnt - CNT_W'(1);
               end
               ST_CAPTURE: begin
                  if (dec_cnt == 8'd0) begin
                     dec_cnt <= dec_reload;
                     bcnt    <= bcnt - CNT_W'(1);
                     even_k  <= ~even_k;
                     if (even_k) begin
                        low_byte <= ad_q;
                        if (bcnt == CNT_W'(1)) begin
                           wr_q   <= 1'b1;
                           data_q <= {8'h00, ad_q};
                        end
                     end else begin
                        wr_q   <= 1'b1;
                        data_q <= {ad_q, low_byte};
                     end
                     if (bcnt == CNT_W'(1))
                        state <= ST_LAST;
                  end else begin
                     dec_cnt <= dec_cnt - 8'd1;
                  end
               end
               ST_LAST: state <= ST_DONE;
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // sticky overrun, cleared only when a new capture is accepted
   always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
      if (!i_rst_n)
         overrun_q <= 1'b0;
      else if (accept)
         overrun_q <= 1'b0;
      else if (wr_q && bus.i_fifo_full)
         overrun_q <= 1'b1;
   end

   // saturating count of edges that arrive while a capture is in progress
   always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
      if (!i_rst_n)
         miss_q <= '0;
      else if (trig_edge && run_s && state != ST_IDLE && miss_q != '1)
         miss_q <= miss_q + MISS_W'(1);
   end

   // full is sampled in the write cycle itself so no word is lost silently
   assign bus.o_fifo_wr   = wr_q & ~bus.i_fifo_full;
   assign bus.o_fifo_data = data_q;
   assign bus.o_busy      = (state != ST_IDLE);
   assign bus.o_done      = (state == ST_DONE);
   assign bus.o_overrun   = overrun_q;
   assign bus.o_trig_miss = miss_q;
endmodule
